// File: rtl/mac_result_reader_pkg.sv
// Shared definitions for the MAC result buffer: slot geometry, drain FSM
// encoding and slot helpers used by the MAC and the result reader.
package mac_result_reader_pkg;

  localparam int WORDS  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = WORDS * BYTE_W;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [BYTE_W-1:0] slot_sel(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  sel);
    return word[sel*BYTE_W +: BYTE_W];
  endfunction

  // Counts above the slot count saturate so a bogus count never drains garbage.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(WORDS)) ? CNT_W'(WORDS) : c;
  endfunction

endpackage

// File: rtl/mac_result_reader_if.sv
// Byte output stream of the result reader.
// Valid/ready: a byte transfers on every rising edge where out_valid and out_ready
// are both high; once raised, out_valid stays high and out_data/out_addr stay stable
// until that transfer happens.
interface mac_result_reader_if #(parameter int ADDR_W = 16);
  import mac_result_reader_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_addr, output out_valid, input out_ready);
  modport slave  (input out_data, input out_addr, input out_valid, output out_ready);

endinterface

// File: rtl/mac_result_reader_res_byte_mux.sv
// Combinational WORDS:1 slot selector on the snapshotted result word.
module res_byte_mux
  import mac_result_reader_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  sel,
  output logic [BYTE_W-1:0] byte_out
);

  assign byte_out = slot_sel(word, sel);

endmodule

// File: rtl/mac_result_reader.sv
// Drains a snapshot of the packed MAC result word as a byte stream with a
// persistent output address, then pulses the MAC result-buffer clear.
module mac_result_reader
  import mac_result_reader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORD_W-1:0]          res_word,
  input  logic [CNT_W-1:0]           res_count,
  input  logic                       addr_clr,
  output logic                       busy,
  output logic                       done,
  output logic                       clr_res,
  output state_t                     state_dbg,
  mac_result_reader_if.master        out_if
);

  state_t              state, next_state;
  logic [WORD_W-1:0]   shadow;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    idx;
  logic [ADDR_W-1:0]   addr;
  logic [BYTE_W-1:0]   mux_byte;
  logic                hs;

  res_byte_mux u_mux (
    .word     (shadow),
    .sel      (idx[IDX_W-1:0]),
    .byte_out (mux_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    hs         = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = (sat_count(res_count) == '0) ? S_DONE : S_SEND;
      S_SEND: begin
        hs = out_if.out_ready;
        if (hs && (idx == cnt - CNT_W'(1))) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Snapshot only in IDLE, so a start during a drain never disturbs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
      idx    <= '0;
      addr   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        shadow <= res_word;
        cnt    <= sat_count(res_count);
        idx    <= '0;
      end else if (hs) begin
        idx <= idx + CNT_W'(1);
      end
      if (addr_clr)  addr <= '0;
      else if (hs)   addr <= addr + ADDR_W'(1);
    end
  end

  assign out_if.out_valid = (state == S_SEND);
  assign out_if.out_data  = (state == S_SEND) ? mux_byte : '0;
  assign out_if.out_addr  = addr;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);
  assign clr_res          = (state == S_DONE);
  assign state_dbg        = state;

endmodule

// File: tb/tb_mac_result_reader.sv
// Self-checking bench for mac_result_reader: byte queue reference model plus
// a modular address model, exercised by directed and randomized drains.
module tb_mac_result_reader;
  import mac_result_reader_pkg::*;

  localparam int TB_ADDR_W = 4;
  localparam int ADDR_MOD  = 1 << TB_ADDR_W;

  logic                clk;
  logic                rst;
  logic                start;
  logic [WORD_W-1:0]   res_word;
  logic [CNT_W-1:0]    res_count;
  logic                addr_clr;
  logic                busy;
  logic                done;
  logic                clr_res;
  state_t              state_dbg;

  mac_result_reader_if #(.ADDR_W(TB_ADDR_W)) out_if ();

  mac_result_reader #(.ADDR_W(TB_ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_word  (res_word),
    .res_count (res_count),
    .addr_clr  (addr_clr),
    .busy      (busy),
    .done      (done),
    .clr_res   (clr_res),
    .state_dbg (state_dbg),
    .out_if    (out_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BYTE_W-1:0] exp_q[$];
  int model_addr = 0;

  // One full drain: mode 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run_drain(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] c,
                           input int mode, input int mid_start_at, input int clr_at,
                           input string tag);
    int n;
    int cyc;
    int seen_done;
    logic [BYTE_W-1:0] exp_b;
    n = (c > 4) ? 4 : int'(c);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(w[8*i +: 8]);
    res_word  = w;
    res_count = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    res_word = $urandom;
    cyc = 0;
    seen_done = 0;
    while (!seen_done && cyc < 60) begin
      cyc++;
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL %s busy: got %b expected 1 (cycle %0d)", tag, busy, cyc);
      end
      checks++;
      if (clr_res !== done) begin
        errors++; $display("FAIL %s clr_res: got %b expected %b", tag, clr_res, done);
      end
      if (!done && exp_q.size() > 0) begin
        checks++;
        if (out_if.out_valid !== 1'b1) begin
          errors++; $display("FAIL %s valid: got %b expected 1 (cycle %0d)", tag, out_if.out_valid, cyc);
        end
      end
      if (out_if.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_byte: got %02h expected none", tag, out_if.out_data);
        end else begin
          exp_b = exp_q[0];
          checks++;
          if (out_if.out_data !== exp_b) begin
            errors++; $display("FAIL %s data: got %02h expected %02h", tag, out_if.out_data, exp_b);
          end
          if (out_if.out_addr !== TB_ADDR_W'(model_addr)) begin
            errors++; $display("FAIL %s addr: got %0d expected %0d", tag, out_if.out_addr, model_addr);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (exp_q.size() != 0) begin
          errors++; $display("FAIL %s lost_bytes: got %0d remaining expected 0", tag, exp_q.size());
        end
        if (mode == 0) begin
          checks++;
          if (cyc != n + 1) begin
            errors++; $display("FAIL %s done_latency: got %0d expected %0d", tag, cyc, n + 1);
          end
        end
      end
      case (mode)
        0:       out_if.out_ready = 1'b1;
        1:       out_if.out_ready = (cyc % 3 == 1);
        default: out_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == mid_start_at) begin
        start     = 1'b1;
        res_word  = $urandom;
        res_count = 3'($urandom_range(0, 7));
      end
      addr_clr = (cyc == clr_at);
      if (out_if.out_valid === 1'b1 && out_if.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        model_addr = (model_addr + 1) % ADDR_MOD;
      end
      if (addr_clr) model_addr = 0;
      @(posedge clk); #1;
      start    = 1'b0;
      addr_clr = 1'b0;
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL %s timeout: got no done expected done within 60 cycles", tag);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_if.out_valid !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL %s idle_after: got busy=%b done=%b valid=%b expected 0,0,0", tag, busy, done, out_if.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_word = '0; res_count = '0; addr_clr = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_if.out_valid !== 1'b0 || out_if.out_data !== 8'h00 || out_if.out_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || clr_res !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL reset: got valid=%b data=%02h addr=%0d busy=%b done=%b clr=%b expected all 0",
                         out_if.out_valid, out_if.out_data, out_if.out_addr, busy, done, clr_res);
    end
    rst = 1'b0;
    model_addr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_drain(32'hDDCCBBAA, 3'd4, 0, -1, -1, "basic");
    checks++;
    if (out_if.out_addr !== TB_ADDR_W'(4)) begin
      errors++; $display("FAIL basic_next_addr: got %0d expected 4", out_if.out_addr);
    end
  endtask

  task automatic test_stall();
    run_drain(32'hDDCCBBAA, 3'd4, 1, -1, -1, "stall");
    run_drain($urandom, 3'd3, 1, -1, -1, "stall3");
  endtask

  task automatic test_count_edges();
    run_drain($urandom, 3'd0, 0, -1, -1, "count0");
    run_drain($urandom, 3'd7, 0, -1, -1, "count7");
    run_drain($urandom, 3'd5, 2, -1, -1, "count5");
    run_drain($urandom, 3'd1, 0, -1, -1, "count1");
  endtask

  task automatic test_mid_start();
    logic [TB_ADDR_W-1:0] a0;
    a0 = TB_ADDR_W'(model_addr);
    run_drain(32'h44332211, 3'd4, 0, 2, -1, "mid_start");
    checks++;
    if (out_if.out_addr !== a0 + TB_ADDR_W'(4)) begin
      errors++; $display("FAIL mid_start_addr: got %0d expected %0d", out_if.out_addr, a0 + TB_ADDR_W'(4));
    end
    run_drain(32'h88776655, 3'd2, 2, 1, -1, "mid_start_b2b");
  endtask

  task automatic test_wrap();
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    model_addr = 0;
    run_drain($urandom, 3'd4, 0, -1, -1, "wrap_fill0");
    run_drain($urandom, 3'd4, 0, -1, -1, "wrap_fill1");
    run_drain($urandom, 3'd4, 0, -1, -1, "wrap_fill2");
    run_drain($urandom, 3'd2, 0, -1, -1, "wrap_fill3");
    checks++;
    if (out_if.out_addr !== TB_ADDR_W'(14)) begin
      errors++; $display("FAIL wrap_preset: got %0d expected 14", out_if.out_addr);
    end
    run_drain(32'hA3A2A1A0, 3'd4, 0, -1, -1, "wrap");
    checks++;
    if (out_if.out_addr !== TB_ADDR_W'(2)) begin
      errors++; $display("FAIL wrap_end: got %0d expected 2", out_if.out_addr);
    end
    // clear lands on the second handshake: bytes 3 and 4 go to 0 and 1
    run_drain(32'hB3B2B1B0, 3'd4, 0, -1, 2, "clr_hs");
    checks++;
    if (out_if.out_addr !== TB_ADDR_W'(2)) begin
      errors++; $display("FAIL clr_hs_end: got %0d expected 2", out_if.out_addr);
    end
  endtask

  task automatic test_async_reset();
    res_word = 32'h5A4B3C2D; res_count = 3'd4; start = 1'b1;
    out_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_if.out_valid !== 1'b0 || out_if.out_data !== 8'h00 || out_if.out_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || clr_res !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid=%b data=%02h addr=%0d busy=%b done=%b expected all 0",
                         out_if.out_valid, out_if.out_data, out_if.out_addr, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_addr = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0 || clr_res !== 1'b0 || out_if.out_valid !== 1'b0) begin
        errors++; $display("FAIL async_reset_quiet: got done=%b clr=%b valid=%b expected 0", done, clr_res, out_if.out_valid);
      end
      @(posedge clk); #1;
    end
    run_drain(32'h0F1E2D3C, 3'd4, 0, -1, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_drain($urandom, 3'($urandom_range(0, 7)), 2,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1,
                "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_count_edges();
    test_mid_start();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
